// File: rtl/cp0_int_arbiter.sv
// cp0_int_arbiter: nested fixed-priority interrupt arbiter sitting between three raw
// interrupt lines and the CP0 exception logic; one request at a time, unwound on eret.
module cp0_int_arbiter #(
    parameter int NSRC = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] intsrc,
    input  logic            ie,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_din,
    input  logic            int_ack,
    input  logic            eret,
    output logic            int_req,
    output logic [1:0]      int_vec,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] in_service,
    output logic [1:0]      level
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [NSRC-1:0] sync1;
    logic [NSRC-1:0] sync2;
    logic [NSRC-1:0] sync2_d;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] allowed;
    logic [NSRC-1:0] elig;
    logic [NSRC-1:0] pending_next;
    logic [NSRC-1:0] in_service_next;
    logic [1:0]      pick;
    logic [1:0]      top_svc;
    logic [1:0]      vec_next;
    logic [1:0]      level_next;
    logic            req_next;
    logic            ack_take;

    assign rise = sync2 & ~sync2_d;

    // A source may pre-empt only if it ranks strictly above every active handler.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        allowed = '1;
        top_svc = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (in_service[i]) begin
                top_svc = 2'(i);
                for (int j = 0; j < NSRC; j++) begin
                    if (j <= i) allowed[j] = 1'b0;
                end
            end
        end
    end

    assign elig = pending & mask & allowed;

    // Ascending scan: the last eligible index seen is the highest priority one.
    always_comb begin
        pick = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (elig[i]) pick = 2'(i);
        end
    end

    always_comb begin
        state_next = state;
        req_next   = 1'b0;
        vec_next   = int_vec;
        ack_take   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ie && (|elig)) begin
                    state_next = ST_REQ;
                    req_next   = 1'b1;
                    vec_next   = pick;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    ack_take   = 1'b1;
                    state_next = ST_WAIT;
                end else if (!ie || !mask[int_vec]) begin
                    state_next = ST_IDLE;
                end else begin
                    req_next = 1'b1;
                end
            end
            ST_WAIT: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // eret retires the innermost handler before a same-cycle ack opens a new one,
    // and a fresh edge re-arms a source even as its ack clears it.
    always_comb begin
        in_service_next = in_service;
        if (eret && (|in_service)) in_service_next[top_svc] = 1'b0;
        if (ack_take) in_service_next[int_vec] = 1'b1;

        pending_next = pending;
        if (ack_take) pending_next[int_vec] = 1'b0;
        pending_next = pending_next | rise;

        level_next = '0;
        for (int i = 0; i < NSRC; i++) begin
            level_next = level_next + 2'(in_service_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state      <= ST_IDLE;
            sync1      <= '0;
            sync2      <= '0;
            sync2_d    <= '0;
            mask       <= '1;
            pending    <= '0;
            in_service <= '0;
            level      <= '0;
            int_req    <= 1'b0;
            int_vec    <= '0;
        end else begin
            state      <= state_next;
            sync1      <= intsrc;
            sync2      <= sync1;
            sync2_d    <= sync2;
            if (mask_we) mask <= mask_din;
            pending    <= pending_next;
            in_service <= in_service_next;
            level      <= level_next;
            int_req    <= req_next;
            int_vec    <= vec_next;
        end
    end

    a_level_popcount : assert property (@(posedge clk) disable iff (!rst)
        level == 2'($countones(in_service)));

    a_req_only_in_req : assert property (@(posedge clk) disable iff (!rst)
        int_req |-> (state == ST_REQ));

endmodule

// File: tb/tb_cp0_int_arbiter.sv
// tb_cp0_int_arbiter: directed plus randomized stimulus; a behavioural model predicts
// each cycle's registered outputs into a queue that an independent monitor drains.
module tb_cp0_int_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] intsrc = '0;
    logic       ie = 1'b0;
    logic       mask_we = 1'b0;
    logic [2:0] mask_din = '0;
    logic       int_ack = 1'b0;
    logic       eret = 1'b0;
    logic       int_req;
    logic [1:0] int_vec;
    logic [2:0] pending;
    logic [2:0] in_service;
    logic [1:0] level;

    always #5 clk = ~clk;

    cp0_int_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .intsrc     (intsrc),
        .ie         (ie),
        .mask_we    (mask_we),
        .mask_din   (mask_din),
        .int_ack    (int_ack),
        .eret       (eret),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .pending    (pending),
        .in_service (in_service),
        .level      (level)
    );

    typedef struct packed {
        logic       req;
        logic [1:0] vec;
        logic [2:0] pend;
        logic [2:0] svc;
        logic [1:0] lvl;
    } snap_t;

    snap_t exp_q[$];
    int    total  = 0;
    int    passed = 0;

    // Reference model: raw samples of intsrc at the last three edges ([0] newest),
    // plus handshake phase 0 = idle, 1 = requesting, 2 = one-cycle cool-down.
    bit [2:0] m_hist[3];
    bit [2:0] m_pend;
    bit [2:0] m_svc;
    bit [2:0] m_mask;
    int       m_phase;
    int       m_vec;

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
        m_pend  = '0;
        m_svc   = '0;
        m_mask  = 3'b111;
        m_phase = 0;
        m_vec   = 0;
    endtask

    task automatic model_edge(input bit [2:0] src, input bit en, input bit mwe,
                              input bit [2:0] mdin, input bit ack, input bit er);
        int       top;
        int       best;
        int       next_phase;
        bit       took;
        bit [2:0] newly;
        top  = -1;
        best = -1;
        newly = m_hist[1] & ~m_hist[2];
        for (int i = 0; i < 3; i++) if (m_svc[i]) top = i;
        for (int i = 0; i < 3; i++) if (m_pend[i] && m_mask[i] && i > top) best = i;
        took = (m_phase == 1) && ack;
        next_phase = m_phase;
        if (m_phase == 0) begin
            if (en && best >= 0) begin
                next_phase = 1;
                m_vec = best;
            end
        end else if (m_phase == 1) begin
            if (ack) next_phase = 2;
            else if (!en || !m_mask[m_vec]) next_phase = 0;
        end else begin
            next_phase = 0;
        end
        if (er && top >= 0) m_svc[top] = 1'b0;
        if (took) begin
            m_svc[m_vec]  = 1'b1;
            m_pend[m_vec] = 1'b0;
        end
        m_pend = m_pend | newly;
        if (mwe) m_mask = mdin;
        m_phase = next_phase;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = src;
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, advance to the next negedge.
    task automatic step(input logic [2:0] src, input logic en = 1'b1, input logic ack = 1'b0,
                        input logic er = 1'b0, input logic mwe = 1'b0,
                        input logic [2:0] mdin = 3'b111);
        snap_t e;
        intsrc   = src;
        ie       = en;
        int_ack  = ack;
        eret     = er;
        mask_we  = mwe;
        mask_din = mdin;
        model_edge(src, en, mwe, mdin, ack, er);
        e.req  = (m_phase == 1);
        e.vec  = 2'(m_vec);
        e.pend = m_pend;
        e.svc  = m_svc;
        e.lvl  = 2'($countones(m_svc));
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wait_req(input logic [2:0] src, input logic [1:0] vec);
        int n;
        n = 0;
        while (m_phase != 1 && n < 12) begin
            step(src);
            n++;
        end
        check("wait_req", 3'(int_req), 3'd1);
        check("wait_vec", 3'(int_vec), 3'(vec));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, 3'(int_req), 3'd0);
        check({tag, "_vec"}, 3'(int_vec), 3'd0);
        check({tag, "_pend"}, pending, 3'd0);
        check({tag, "_svc"}, in_service, 3'd0);
        check({tag, "_lvl"}, 3'(level), 3'd0);
    endtask

    // Monitor: compares every registered output shortly after each rising edge.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("int_req", 3'(int_req), 3'(e.req));
                check("int_vec", 3'(int_vec), 3'(e.vec));
                check("pending", pending, e.pend);
                check("in_service", in_service, e.svc);
                check("level", 3'(level), 3'(e.lvl));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] r_src;
        logic       r_ack;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;

        // Single source: edge, pending, request, ack.
        step(3'b001);
        step(3'b001);
        step(3'b000);
        wait_req(3'b000, 2'd0);
        step(3'b000, 1'b1, 1'b1);
        check("t1_svc", in_service, 3'b001);
        check("t1_lvl", 3'(level), 3'd1);
        check("t1_pend", pending, 3'b000);
        step(3'b000);

        // Nesting: source 2 pre-empts source 0, then two erets unwind.
        wait_req(3'b100, 2'd2);
        step(3'b100, 1'b1, 1'b1);
        check("t2_svc", in_service, 3'b101);
        check("t2_lvl", 3'(level), 3'd2);
        step(3'b100, 1'b1, 1'b0, 1'b1);
        check("t2_eret1", in_service, 3'b001);
        step(3'b100, 1'b1, 1'b0, 1'b1);
        check("t2_eret2", in_service, 3'b000);
        repeat (3) step(3'b000);

        // Lower priority blocked while source 2 is active, served after eret.
        wait_req(3'b100, 2'd2);
        step(3'b100, 1'b1, 1'b1);
        repeat (6) step(3'b110);
        check("t3_blocked", 3'(int_req), 3'd0);
        step(3'b110, 1'b1, 1'b0, 1'b1);
        step(3'b110);
        check("t3_req", 3'(int_req), 3'd1);
        check("t3_vec", 3'(int_vec), 3'd1);
        step(3'b110, 1'b1, 1'b1);
        step(3'b110, 1'b1, 1'b0, 1'b1);
        repeat (3) step(3'b000);

        // Higher-priority arrival while requesting does not disturb int_vec.
        wait_req(3'b001, 2'd0);
        repeat (4) step(3'b101);
        check("t4_hold_vec", 3'(int_vec), 3'd0);
        step(3'b101, 1'b1, 1'b1);
        wait_req(3'b101, 2'd2);
        step(3'b101, 1'b1, 1'b1);
        check("t4_nested", in_service, 3'b101);
        step(3'b101, 1'b1, 1'b0, 1'b1);
        step(3'b101, 1'b1, 1'b0, 1'b1);
        repeat (3) step(3'b000);

        // Withdraw on ie low, then re-request the same vector.
        wait_req(3'b001, 2'd0);
        step(3'b001, 1'b0);
        check("t5_withdraw", 3'(int_req), 3'd0);
        check("t5_pend", pending, 3'b001);
        wait_req(3'b001, 2'd0);
        step(3'b001, 1'b1, 1'b1);
        step(3'b001, 1'b1, 1'b0, 1'b1);
        repeat (3) step(3'b000);

        // Masked source stays pending until the mask is reopened.
        step(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 3'b110);
        repeat (6) step(3'b001);
        check("t6_masked", 3'(int_req), 3'd0);
        check("t6_pend", pending, 3'b001);
        step(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 3'b111);
        wait_req(3'b001, 2'd0);
        step(3'b001, 1'b1, 1'b1);
        step(3'b001, 1'b1, 1'b0, 1'b1);
        repeat (3) step(3'b000);

        // Randomized traffic, acks mostly while requesting, stray acks and erets elsewhere.
        r_src = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0) r_src[b] = ~r_src[b];
            end
            r_ack = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            step(r_src, $urandom_range(0, 9) != 0, r_ack, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 24) == 0, 3'($urandom_range(0, 7)));
        end

        // Reset dropped mid-handshake clears outputs without a clock edge.
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(3'b001);
        step(3'b001);
        wait_req(3'b000, 2'd0);
        #2;
        rst = 1'b0;
        #1;
        check_reset("async_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cp0_int_arbiter.md
# cp0_int_arbiter

Nested-priority interrupt arbiter between the three external interrupt sources and the CPU pipeline's CP0 exception logic. It synchronises and edge-detects raw sources, keeps per-source pending and in-service state, and applies a per-source mask plus the global Status.IE. It issues one interrupt request at a time to the pipeline using a request/acknowledge handshake, and unwinds nesting on `eret`.

## Interface
- `NSRC`, 3: number of interrupt sources. Fixed at 3 in this revision; index 2 has the highest priority.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; 0 forces every register to its reset value immediately.
- `intsrc`  in  3  raw level interrupt sources, asynchronous to `clk`.
- `ie`  in  1  global interrupt enable (CP0 Status.IE).
- `mask_we`  in  1  write strobe for the mask register.
- `mask_din`  in  3  new mask value; 1 = source enabled.
- `int_ack`  in  1  one-cycle pulse from the pipeline when it takes the interrupt (the cycle EPC is captured).
- `eret`  in  1  one-cycle pulse when ERET retires.
- `int_req`  out  1  interrupt request to the pipeline.
- `int_vec`  out  2  index of the requested source, 0..2.
- `pending`  out  3  latched, unserviced edges.
- `in_service`  out  3  sources whose handlers are currently active.
- `level`  out  2  nesting depth, 0..3 (popcount of `in_service`).

## Operation
- Reset values: `int_req`=0, `int_vec`=0, `pending`=000, `in_service`=000, `level`=0, mask=111, synchroniser and edge flops 0, FSM=IDLE.
- **Source capture**
  - Each source passes through a two-flop synchroniser, then a rising-edge detector (sync2 & ~sync2_d).
  - An edge sets `pending[i]`. A level held high produces only one edge.
- **Priority and eligibility**
  - Priority is fixed: 2 > 1 > 0.
  - `elig[i]` = `pending[i]` & `mask[i]` & (i > index of highest set `in_service` bit, or `in_service`=0).
  - A source never pre-empts an equal- or higher-priority handler.
- **Mask register**
  - Written on `mask_we`; the new value is effective from the next cycle.
  - Masking a source does not clear its pending bit.
- **FSM states: IDLE, REQ, WAIT**
  - IDLE: if `ie` & |`elig`, latch `int_vec` = highest eligible index and go to REQ.
  - REQ: `int_req`=1 and `int_vec` is held stable. A higher-priority arrival does not change `int_vec`.
    - If `int_ack`: clear `pending[int_vec]`, set `in_service[int_vec]`, go to WAIT.
    - Else if `ie`=0 or `mask[int_vec]`=0: withdraw, go to IDLE with `int_req`=0.
  - WAIT: exactly one cycle, to let CP0 clear IE. Always returns to IDLE.
  - `int_ack` outside REQ is ignored.
- **eret**
  - Clears the highest set `in_service` bit.
  - With `in_service`=000, `eret` has no effect and `level` stays 0.
  - `eret` is accepted in any FSM state.
- **Simultaneous events**
  - New edge on source i in the same cycle as its ack clear: the set wins, and `pending[i]` stays 1.
  - `eret` and `int_ack` in the same cycle: apply the `eret` clear first, then the ack set. `level` is unchanged net.
  - `mask_we` in the same cycle as `int_ack`: the ack completes using the old mask.
- `level` is always equal to the popcount of `in_service`; it never wraps.
- Reset asserted mid-handshake: `int_req` drops asynchronously and all state is lost. The pipeline must treat this as no interrupt taken.

## Timing
- `intsrc[i]` rises before edge k:
  - sync1=1 after k, sync2=1 after k+1.
  - `pending[i]`=1 after k+2.
  - `int_req`=1 after k+3 if eligible and `ie`=1.
- `int_ack` sampled at edge m:
  - `int_req`=0 and `in_service` updated after m.
  - FSM returns to IDLE after m+1.
  - Earliest next `int_req` is after m+2.
- Withdraw: `ie` or mask bit low at edge m means `int_req`=0 after m.
- `eret` at edge m: `in_service`/`level` updated after m. A newly eligible lower-priority source can raise `int_req` after m+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, `ie`=1, pulse `intsrc`=001 for 2 cycles:
  - `pending`=001 three edges later and `int_req`=1, `int_vec`=0 one edge after that.
  - `int_ack` gives `in_service`=001, `level`=1, `pending`=000.
- Source 0 in service, raise source 2, `ie`=1:
  - Request with `int_vec`=2.
  - After ack: `in_service`=101, `level`=2.
  - Two `eret` pulses give 001, then 000.
- Source 2 in service, raise source 1:
  - No request.
  - After `eret`, `int_req`=1 with `int_vec`=1 two edges later.
- In REQ with `int_vec`=0, raise source 2 before ack:
  - `int_vec` stays 0.
  - After ack plus WAIT, a second request with `int_vec`=2 (nested).
- In REQ, drive `ie`=0 for one cycle:
  - `int_req`=0 next edge and `pending` is retained.
  - `ie`=1 again re-requests the same vector.
- Apply `mask_din`=110 and raise source 0:
  - No request and `pending[0]`=1.
  - Write mask 111: request with `int_vec`=0.
- Pull `rst` low while `int_req`=1:
  - All outputs go to reset values immediately, without waiting for a clock edge.
